// File: rtl/cc_puncture_if.sv
// Handshake bundle between the encoder, the puncturing stage and the interleaver.
// The slave modport is the puncturing stage; the master modport is whoever drives it.
interface cc_puncture_if;
    logic [1:0] rate;
    logic       valid_in;
    logic       sof_in;
    logic [1:0] z_in;
    logic       in_ready;
    logic       valid_out;
    logic       bit_out;

    // valid/ready: a pair moves on a rising edge where valid_in && in_ready;
    // the output side has no ready, so valid_out/bit_out must be taken every cycle.
    modport master (
        output rate, valid_in, sof_in, z_in,
        input  in_ready, valid_out, bit_out
    );

    modport slave (
        input  rate, valid_in, sof_in, z_in,
        output in_ready, valid_out, bit_out
    );
endinterface

// File: rtl/cc_puncture.sv
// 802.16 OFDM puncturer: takes {Y,X} mother-code pairs, keeps the bits the rate's
// pattern selects and serialises them one per cycle through a two-bit buffer.
module cc_puncture #(
    parameter logic [1:0] RATE_RST = 2'b00
) (
    input  logic         clk,
    input  logic         reset,
    cc_puncture_if.slave bus
);

    logic [1:0] rate_q, rate_d;
    logic [2:0] idx_q, idx_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] buf_q, buf_d;

    logic       xfer;
    logic [1:0] eff_rate;
    logic [2:0] eff_idx;
    logic [2:0] period;
    logic [0:4] x_mask;
    logic [0:4] y_mask;
    logic       keep_x;
    logic       keep_y;

    assign bus.in_ready  = (cnt_q <= 2'd1);
    assign bus.valid_out = (cnt_q != 2'd0);
    assign bus.bit_out   = buf_q[0];

    always_comb begin
        xfer     = bus.valid_in && bus.in_ready;
        eff_rate = bus.sof_in ? bus.rate : rate_q;
        eff_idx  = bus.sof_in ? 3'd0 : idx_q;

        // Masks read left to right from pattern position 0.
        case (eff_rate)
            2'b00:   begin period = 3'd1; x_mask = 5'b10000; y_mask = 5'b10000; end
            2'b01:   begin period = 3'd2; x_mask = 5'b10000; y_mask = 5'b11000; end
            2'b10:   begin period = 3'd3; x_mask = 5'b10100; y_mask = 5'b11000; end
            default: begin period = 3'd5; x_mask = 5'b10101; y_mask = 5'b11010; end
        endcase
        keep_x = x_mask[eff_idx];
        keep_y = y_mask[eff_idx];

        rate_d = rate_q;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        buf_d  = buf_q;

        if (cnt_q != 2'd0) begin
            buf_d = {1'b0, buf_q[1]};
            cnt_d = cnt_q - 2'd1;
        end

        // in_ready implies cnt_q<=1, so the drain above has emptied the buffer.
        if (xfer) begin
            case ({keep_y, keep_x})
                2'b11:   begin buf_d = {bus.z_in[1], bus.z_in[0]}; cnt_d = 2'd2; end
                2'b01:   begin buf_d = {1'b0, bus.z_in[0]};        cnt_d = 2'd1; end
                default: begin buf_d = {1'b0, bus.z_in[1]};        cnt_d = 2'd1; end
            endcase
            idx_d = (eff_idx == period - 3'd1) ? 3'd0 : eff_idx + 3'd1;
            if (bus.sof_in) begin
                rate_d = bus.rate;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rate_q <= RATE_RST;
            idx_q  <= 3'd0;
            cnt_q  <= 2'd0;
            buf_q  <= 2'd0;
        end else begin
            rate_q <= rate_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            buf_q  <= buf_d;
        end
    end

endmodule
